// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared constants and FSM encoding for the pipeline sequencer
package pipeline_pkg;

  // Register index width for rs1/rs2/rd fields
  localparam int REG_IDX_W = 5;

  // Canonical RISC-V NOP (addi x0, x0, 0) loaded into IF/ID on a flush
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Sequencer states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } ctrl_state_e;

endpackage

// File: rtl/hazard_detect.sv
// rtl/hazard_detect.sv - combinational load-use hazard comparator
module hazard_detect
  import pipeline_pkg::*;
(
  input  logic [REG_IDX_W-1:0] if_id_rs1,
  input  logic [REG_IDX_W-1:0] if_id_rs2,
  input  logic                 if_id_rs2_used,
  input  logic [REG_IDX_W-1:0] id_ex_rd,
  input  logic                 id_ex_mem_read,
  output logic                 stall
);

  // A load in ID/EX whose destination feeds the instruction in IF/ID; x0 never creates a dependency
  assign stall = id_ex_mem_read
              && (id_ex_rd != '0)
              && ((id_ex_rd == if_id_rs1) || (if_id_rs2_used && (id_ex_rd == if_id_rs2)));

endmodule

// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - 5-stage pipeline sequencer (enables, flushes, run/drain FSM); PIPELINE_CTRL_PERF_CNT_EN adds stall/flush counters
module pipeline_ctrl
  import pipeline_pkg::*;
#(
  parameter int DRAIN_CYCLES = 4,
  parameter int CNT_W        = 32
) (
  input  logic                 clk,
  input  logic                 arst_n,
  input  logic                 enable,
  input  logic [REG_IDX_W-1:0] if_id_rs1,
  input  logic [REG_IDX_W-1:0] if_id_rs2,
  input  logic                 if_id_rs2_used,
  input  logic [REG_IDX_W-1:0] id_ex_rd,
  input  logic                 id_ex_mem_read,
  input  logic                 jump_id,
  input  logic                 branch_taken_mem,
  output logic                 pc_en,
  output logic                 if_id_en,
  output logic                 id_ex_en,
  output logic                 if_id_flush,
  output logic                 id_ex_flush,
  output logic                 ex_mem_flush,
  output logic                 running,
  output logic                 drained,
  output logic [CNT_W-1:0]     stall_cnt,
  output logic [CNT_W-1:0]     flush_cnt
);

  localparam int DCNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DCNT_W-1:0] DRAIN_LOAD = DCNT_W'(DRAIN_CYCLES - 1);

  ctrl_state_e       state_q, state_d;
  logic [DCNT_W-1:0] dcnt_q, dcnt_d;
  logic              hz_stall;

  hazard_detect u_hazard_detect (
    .if_id_rs1      (if_id_rs1),
    .if_id_rs2      (if_id_rs2),
    .if_id_rs2_used (if_id_rs2_used),
    .id_ex_rd       (id_ex_rd),
    .id_ex_mem_read (id_ex_mem_read),
    .stall          (hz_stall)
  );

  // Next-state and drain-counter logic for the IDLE/RUN/DRAIN sequencer
  always_comb begin
    state_d = state_q;
    dcnt_d  = dcnt_q;
    case (state_q)
      ST_IDLE: begin
        if (enable) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (!enable) begin
          state_d = ST_DRAIN;
          dcnt_d  = DRAIN_LOAD;
        end
      end
      ST_DRAIN: begin
        if (enable) begin
          state_d = ST_RUN;
          dcnt_d  = '0;
        end else if (dcnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          dcnt_d = dcnt_q - 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        dcnt_d  = '0;
      end
    endcase
  end

  // State and drain counter registers; reset abandons any drain in progress
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= ST_IDLE;
      dcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      dcnt_q  <= dcnt_d;
    end
  end

  // Stage enables and flushes, combinational so hazards are answered in the same cycle
  always_comb begin
    pc_en        = 1'b0;
    if_id_en     = 1'b0;
    id_ex_en     = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    running      = 1'b0;
    drained      = 1'b0;
    case (state_q)
      ST_RUN: begin
        running  = 1'b1;
        if_id_en = 1'b1;
        id_ex_en = 1'b1;
        if (branch_taken_mem) begin
          // Redirect wins: the load's consumer is wrong-path and gets squashed anyway
          pc_en        = 1'b1;
          if_id_flush  = 1'b1;
          id_ex_flush  = 1'b1;
          ex_mem_flush = 1'b1;
        end else if (hz_stall) begin
          // Hold PC and IF/ID, insert one bubble into ID/EX
          pc_en       = 1'b0;
          if_id_en    = 1'b0;
          id_ex_flush = 1'b1;
        end else if (jump_id) begin
          pc_en       = 1'b1;
          if_id_flush = 1'b1;
        end else begin
          pc_en = 1'b1;
        end
      end
      ST_DRAIN: begin
        // Fetch frozen, only bubbles enter while older instructions retire
        if_id_en    = 1'b1;
        id_ex_en    = 1'b1;
        if_id_flush = 1'b1;
        drained     = (dcnt_q == '0) && !enable;
      end
      default: begin
      end
    endcase
  end

`ifdef PIPELINE_CTRL_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
  logic             stall_evt, flush_evt;

  // Events only count when they actually win the priority mux in RUN
  assign stall_evt = (state_q == ST_RUN) && !branch_taken_mem && hz_stall;
  assign flush_evt = (state_q == ST_RUN) && (branch_taken_mem || (jump_id && !hz_stall));

  // Saturating event counters, cleared only by reset
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_evt && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 1'b1;
      if (flush_evt && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + 1'b1;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb/tb_pipeline_ctrl.sv - directed self-checking bench for pipeline_ctrl
module tb_pipeline_ctrl;

  localparam int CNT_W = 4;
`ifdef PIPELINE_CTRL_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  // Expected output vectors: {pc_en, if_id_en, id_ex_en, if_id_flush, id_ex_flush, ex_mem_flush, running, drained}
  localparam logic [7:0] O_ZERO  = 8'b0000_0000;
  localparam logic [7:0] O_RUN   = 8'b1110_0010;
  localparam logic [7:0] O_STALL = 8'b0010_1010;
  localparam logic [7:0] O_BR    = 8'b1111_1110;
  localparam logic [7:0] O_JMP   = 8'b1111_0010;
  localparam logic [7:0] O_DRN   = 8'b0111_0000;
  localparam logic [7:0] O_DONE  = 8'b0111_0001;

  logic clk = 1'b0;
  logic arst_n;
  logic enable;
  logic [4:0] if_id_rs1, if_id_rs2, id_ex_rd;
  logic if_id_rs2_used, id_ex_mem_read, jump_id, branch_taken_mem;
  logic pc_en, if_id_en, id_ex_en, if_id_flush, id_ex_flush, ex_mem_flush, running, drained;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  logic [7:0] outs;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pipeline_ctrl #(.DRAIN_CYCLES(4), .CNT_W(CNT_W)) dut (
    .clk              (clk),
    .arst_n           (arst_n),
    .enable           (enable),
    .if_id_rs1        (if_id_rs1),
    .if_id_rs2        (if_id_rs2),
    .if_id_rs2_used   (if_id_rs2_used),
    .id_ex_rd         (id_ex_rd),
    .id_ex_mem_read   (id_ex_mem_read),
    .jump_id          (jump_id),
    .branch_taken_mem (branch_taken_mem),
    .pc_en            (pc_en),
    .if_id_en         (if_id_en),
    .id_ex_en         (id_ex_en),
    .if_id_flush      (if_id_flush),
    .id_ex_flush      (id_ex_flush),
    .ex_mem_flush     (ex_mem_flush),
    .running          (running),
    .drained          (drained),
    .stall_cnt        (stall_cnt),
    .flush_cnt        (flush_cnt)
  );

  assign outs = {pc_en, if_id_en, id_ex_en, if_id_flush, id_ex_flush, ex_mem_flush, running, drained};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Apply hazard-side inputs; outputs are sampled #1 later, well before the next edge
  task automatic drive(input logic mr, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic r2u, input logic jmp, input logic br);
    id_ex_mem_read   = mr;
    id_ex_rd         = rd;
    if_id_rs1        = rs1;
    if_id_rs2        = rs2;
    if_id_rs2_used   = r2u;
    jump_id          = jmp;
    branch_taken_mem = br;
    #1;
  endtask

  task automatic quiet();
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    arst_n = 1'b0;
    enable = 1'b0;
    if_id_rs1 = '0; if_id_rs2 = '0; id_ex_rd = '0;
    if_id_rs2_used = 1'b0; id_ex_mem_read = 1'b0; jump_id = 1'b0; branch_taken_mem = 1'b0;
    #3;
    check("reset_outs", 32'(outs), 32'(O_ZERO));
    check("reset_stall_cnt", 32'(stall_cnt), 32'd0);
    check("reset_flush_cnt", 32'(flush_cnt), 32'd0);

    // 1: leave reset, request run
    cyc(); arst_n = 1'b1;
    cyc(); #1;
    check("idle_outs", 32'(outs), 32'(O_ZERO));
    enable = 1'b1; #1;
    check("idle_before_edge", 32'(outs), 32'(O_ZERO));
    cyc(); quiet();
    check("run_default", 32'(outs), 32'(O_RUN));

    // 2: load-use via rs1, then x0, then rs2 gated by rs2_used
    cyc(); drive(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0);
    check("lu_rs1_stall", 32'(outs), 32'(O_STALL));
    cyc(); quiet();
    check("lu_one_cycle", 32'(outs), 32'(O_RUN));
    check("lu_stall_cnt", 32'(stall_cnt), PERF ? 32'd1 : 32'd0);
    cyc(); drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
    check("lu_x0_nostall", 32'(outs), 32'(O_RUN));
    cyc(); drive(1'b1, 5'd5, 5'd3, 5'd5, 1'b0, 1'b0, 1'b0);
    check("lu_rs2_unused", 32'(outs), 32'(O_RUN));
    cyc(); drive(1'b1, 5'd5, 5'd3, 5'd5, 1'b1, 1'b0, 1'b0);
    check("lu_rs2_used", 32'(outs), 32'(O_STALL));
    cyc(); drive(1'b0, 5'd5, 5'd5, 5'd5, 1'b1, 1'b0, 1'b0);
    check("lu_no_load", 32'(outs), 32'(O_RUN));
    check("stall_cnt_2", 32'(stall_cnt), PERF ? 32'd2 : 32'd0);

    // 3: branch beats a simultaneous load-use hazard
    cyc(); drive(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b1);
    check("branch_over_lu", 32'(outs), 32'(O_BR));
    cyc(); quiet();
    check("branch_one_cycle", 32'(outs), 32'(O_RUN));
    check("branch_stall_cnt", 32'(stall_cnt), PERF ? 32'd2 : 32'd0);
    check("branch_flush_cnt", 32'(flush_cnt), PERF ? 32'd1 : 32'd0);
    cyc(); drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
    check("jump_bubble", 32'(outs), 32'(O_JMP));
    cyc(); drive(1'b1, 5'd7, 5'd7, 5'd0, 1'b0, 1'b1, 1'b0);
    check("lu_over_jump", 32'(outs), 32'(O_STALL));
    cyc(); quiet();
    check("jump_flush_cnt", 32'(flush_cnt), PERF ? 32'd2 : 32'd0);

    // 4: full drain
    enable = 1'b0; #1;
    check("run_enable_low", 32'(outs), 32'(O_RUN));
    for (int i = 0; i < 3; i++) begin
      cyc();
      check($sformatf("drain_%0d", i), 32'(outs), 32'(O_DRN));
    end
    cyc();
    check("drain_done", 32'(outs), 32'(O_DONE));
    cyc();
    check("drain_to_idle", 32'(outs), 32'(O_ZERO));

    // 5a: re-enable during the 2nd drain cycle
    enable = 1'b1;
    cyc();
    check("rerun", 32'(outs), 32'(O_RUN));
    enable = 1'b0;
    cyc();
    check("redrain_1", 32'(outs), 32'(O_DRN));
    cyc();
    enable = 1'b1; #1;
    check("redrain_2_nopulse", 32'(outs), 32'(O_DRN));
    cyc();
    check("reenter_run", 32'(outs), 32'(O_RUN));

    // 5b: reset in the middle of a drain
    enable = 1'b0;
    cyc(); cyc();
    check("pre_reset_drain", 32'(outs), 32'(O_DRN));
    arst_n = 1'b0; #1;
    check("reset_mid_drain", 32'(outs), 32'(O_ZERO));
    check("reset_clr_stall", 32'(stall_cnt), 32'd0);
    check("reset_clr_flush", 32'(flush_cnt), 32'd0);
    cyc(); cyc();
    check("reset_held_idle", 32'(outs), 32'(O_ZERO));
    arst_n = 1'b1;
    cyc();
    check("post_reset_idle", 32'(outs), 32'(O_ZERO));

    // 6: saturation of stall counter, three jump flushes
    enable = 1'b1;
    cyc();
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 5'd9, 5'd9, 5'd0, 1'b0, 1'b0, 1'b0);
      cyc();
    end
    quiet();
    check("stall_sat", 32'(stall_cnt), PERF ? 32'hF : 32'd0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
      cyc();
    end
    quiet();
    check("flush_cnt_3", 32'(flush_cnt), PERF ? 32'd3 : 32'd0);
    check("stall_hold_sat", 32'(stall_cnt), PERF ? 32'hF : 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
